// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm ringer: FSM encoding and default timing constants.
package alarm_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RING   = 2'd1,
        S_SNOOZE = 2'd2
    } state_t;

    localparam int DEF_RING_SECS   = 60;
    localparam int DEF_SNOOZE_SECS = 300;
    localparam int DEF_MAX_SNOOZE  = 3;

endpackage

// File: rtl/sec_countdown.sv
// Loadable seconds down-counter; decrements on each enabled tick and saturates at zero.
module sec_countdown #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         zero
);

    assign zero = (cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (en && !zero)
            cnt <= cnt - 1'b1;
    end

endmodule

// File: rtl/alarm_ring.sv
// Alarm ringer: fires on the rising edge of a minute match, rings for a bounded time,
// and supports a limited number of snoozes per alarm event.
import alarm_pkg::*;

module alarm_ring #(
    parameter int RING_SECS   = DEF_RING_SECS,
    parameter int SNOOZE_SECS = DEF_SNOOZE_SECS,
    parameter int MAX_SNOOZE  = DEF_MAX_SNOOZE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       alarm_en,
    input  logic [3:0] alarm_min1,
    input  logic [3:0] alarm_min2,
    input  logic [3:0] cur_min1,
    input  logic [3:0] cur_min2,
    input  logic [3:0] cur_sec1,
    input  logic [3:0] cur_sec2,
    input  logic       stop,
    input  logic       snooze,
    output logic       ring,
    output logic       beep,
    output logic       snoozing,
    output logic [1:0] snooze_left
);

    localparam int RW = $clog2(RING_SECS);
    localparam int SW = $clog2(SNOOZE_SECS + 1);

    state_t        state, state_nx;
    logic          match, match_d, trigger;
    logic [RW-1:0] ring_cnt;
    logic [SW-1:0] snz_cnt;
    logic          snz_zero, snz_load, snz_en;
    logic          ring_last;

    assign match = (cur_min1 == alarm_min1) && (cur_min2 == alarm_min2) &&
                   (cur_sec1 == 4'd0) && (cur_sec2 == 4'd0);
    assign trigger   = alarm_en && match && !match_d;
    assign ring_last = (ring_cnt == RW'(RING_SECS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    // Buttons beat ticks; stop beats snooze; a disarmed alarm beats everything.
    always_comb begin
        state_nx = state;
        if (!alarm_en)
            state_nx = S_IDLE;
        else begin
            case (state)
                S_IDLE:
                    if (trigger) state_nx = S_RING;
                S_RING:
                    if (stop || (snooze && snooze_left == 2'd0)) state_nx = S_IDLE;
                    else if (snooze)                             state_nx = S_SNOOZE;
                    else if (tick_1hz && ring_last)              state_nx = S_IDLE;
                S_SNOOZE:
                    // snz_zero only guards against an unreachable drained counter
                    if (stop)                                          state_nx = S_IDLE;
                    else if ((tick_1hz && snz_cnt == SW'(1)) || snz_zero) state_nx = S_RING;
                default:
                    state_nx = S_IDLE;
            endcase
        end
    end

    always_comb begin
        ring     = (state == S_RING);
        snoozing = (state == S_SNOOZE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            match_d     <= 1'b0;
            beep        <= 1'b0;
            ring_cnt    <= '0;
            snooze_left <= 2'd0;
        end else begin
            match_d <= match;
            if (state_nx == S_RING && state != S_RING) begin
                ring_cnt <= '0;
                beep     <= 1'b1;
                if (state == S_IDLE)
                    snooze_left <= 2'(MAX_SNOOZE);
            end else if (state == S_RING && state_nx == S_RING) begin
                if (tick_1hz) begin
                    ring_cnt <= ring_cnt + 1'b1;
                    beep     <= ~beep;
                end
            end else begin
                beep <= 1'b0;
            end
            if (state == S_RING && state_nx == S_SNOOZE)
                snooze_left <= snooze_left - 2'd1;
        end
    end

    assign snz_load = (state == S_RING) && (state_nx == S_SNOOZE);
    assign snz_en   = (state == S_SNOOZE) && (state_nx == S_SNOOZE) && tick_1hz;

    sec_countdown #(.W(SW)) u_snooze_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (snz_load),
        .load_val (SW'(SNOOZE_SECS)),
        .en       (snz_en),
        .cnt      (snz_cnt),
        .zero     (snz_zero)
    );

endmodule

// File: tb/tb_alarm_ring.sv
// Self-checking bench for alarm_ring: directed scenarios plus random traffic,
// checked every cycle against a behavioural model of the alarm event.
module tb_alarm_ring;

    localparam int RS = 60;
    localparam int SS = 300;
    localparam int MS = 3;

    logic       clk = 1'b0, rst = 1'b1;
    logic       tick_1hz = 1'b0, alarm_en = 1'b0, stop = 1'b0, snooze = 1'b0;
    logic [3:0] alarm_min1 = 4'd0, alarm_min2 = 4'd7;
    logic [3:0] cur_min1, cur_min2, cur_sec1, cur_sec2;
    logic       ring, beep, snoozing;
    logic [1:0] snooze_left;

    int n_cmp = 0, n_bad = 0;
    int tm = 6, ts = 58;

    assign cur_min1 = 4'(tm / 10);
    assign cur_min2 = 4'(tm % 10);
    assign cur_sec1 = 4'(ts / 10);
    assign cur_sec2 = 4'(ts % 10);

    always #5 clk = ~clk;

    alarm_ring dut (
        .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .alarm_en(alarm_en),
        .alarm_min1(alarm_min1), .alarm_min2(alarm_min2),
        .cur_min1(cur_min1), .cur_min2(cur_min2), .cur_sec1(cur_sec1), .cur_sec2(cur_sec2),
        .stop(stop), .snooze(snooze),
        .ring(ring), .beep(beep), .snoozing(snoozing), .snooze_left(snooze_left)
    );

    // Model: mode 0 = quiet, 1 = ringing (m_rung seconds so far), 2 = snoozing (m_wait seconds to go).
    int m_mode = 0, m_rung = 0, m_wait = 0, m_left = 0;
    bit m_prev = 1'b0;

    always @(posedge clk or posedge rst) begin : model
        bit hit, fire;
        if (rst) begin
            m_mode = 0; m_rung = 0; m_wait = 0; m_left = 0; m_prev = 1'b0;
        end else begin
            hit    = (cur_min1 == alarm_min1) && (cur_min2 == alarm_min2) &&
                     (cur_sec1 == 4'd0) && (cur_sec2 == 4'd0);
            fire   = alarm_en && hit && !m_prev;
            m_prev = hit;
            if (!alarm_en)
                m_mode = 0;
            else if (m_mode == 0) begin
                if (fire) begin m_mode = 1; m_rung = 0; m_left = MS; end
            end else if (m_mode == 1) begin
                if (stop || (snooze && m_left == 0)) m_mode = 0;
                else if (snooze) begin m_mode = 2; m_wait = SS; m_left = m_left - 1; end
                else if (tick_1hz) begin
                    m_rung = m_rung + 1;
                    if (m_rung == RS) m_mode = 0;
                end
            end else begin
                if (stop) m_mode = 0;
                else if (tick_1hz) begin
                    m_wait = m_wait - 1;
                    if (m_wait == 0) begin m_mode = 1; m_rung = 0; end
                end
            end
        end
    end

    // Beep starts high and flips every second rung, so it is high on even elapsed seconds.
    always @(negedge clk) begin : compare
        bit e_ring, e_beep, e_snz;
        e_ring = (m_mode == 1);
        e_snz  = (m_mode == 2);
        e_beep = e_ring && (m_rung % 2 == 0);
        n_cmp++;
        if (ring !== e_ring || beep !== e_beep || snoozing !== e_snz || snooze_left !== 2'(m_left)) begin
            n_bad++;
            $display("FAIL cycle t=%0t ring=%b/%b beep=%b/%b snoozing=%b/%b snooze_left=%0d/%0d (got/want)",
                     $time, ring, e_ring, beep, e_beep, snoozing, e_snz, snooze_left, m_left);
        end
    end

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic step(input bit t, input bit st, input bit sn);
        tick_1hz = t; stop = st; snooze = sn;
        @(posedge clk); #1;
        tick_1hz = 1'b0; stop = 1'b0; snooze = 1'b0;
    endtask

    task automatic adv_time();
        ts++;
        if (ts == 60) begin ts = 0; tm = (tm + 1) % 60; end
    endtask

    task automatic sec();
        adv_time();
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic secs(input int n);
        for (int i = 0; i < n; i++) sec();
    endtask

    task automatic arm();
        tm = 6; ts = 59;
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        sec();
    endtask

    initial begin
        repeat (3) step(1'b0, 1'b0, 1'b0);
        chk("reset_ring", ring, 0);
        chk("reset_beep", beep, 0);
        chk("reset_left", snooze_left, 0);
        rst = 1'b0; alarm_en = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        chk("no_ring_after_release", ring, 0);

        // Ring then time out
        arm();
        chk("ring_on_match", ring, 1);
        chk("beep_on_entry", beep, 1);
        chk("left_loaded", snooze_left, 3);
        sec();
        chk("beep_toggle", beep, 0);
        secs(58);
        chk("ring_at_59", ring, 1);
        sec();
        chk("ring_timeout", ring, 0);

        // Snooze cycle and exhaustion
        arm();
        secs(3);
        step(1'b0, 1'b0, 1'b1);
        chk("snoozing", snoozing, 1);
        chk("left_dec", snooze_left, 2);
        chk("snooze_beep", beep, 0);
        secs(299);
        chk("snooze_299", snoozing, 1);
        sec();
        chk("re_ring", ring, 1);
        chk("re_ring_beep", beep, 1);
        step(1'b0, 1'b0, 1'b1);
        secs(300);
        step(1'b0, 1'b0, 1'b1);
        chk("left_zero", snooze_left, 0);
        secs(300);
        chk("ring_after_3", ring, 1);
        step(1'b0, 1'b0, 1'b1);
        chk("fourth_snooze_idle", ring | snoozing, 0);
        chk("fourth_snooze_left", snooze_left, 0);

        // Stop and snooze together
        arm();
        step(1'b0, 1'b1, 1'b1);
        chk("stop_wins", ring | snoozing, 0);
        chk("left_held", snooze_left, 3);

        // Held match does not re-fire
        arm();
        step(1'b0, 1'b1, 1'b0);
        repeat (5) step(1'b1, 1'b0, 1'b0);
        chk("no_refire", ring, 0);

        // Disarm during snooze
        arm();
        step(1'b0, 1'b0, 1'b1);
        alarm_en = 1'b0;
        step(1'b0, 1'b0, 1'b0);
        chk("disarm_idle", snoozing | ring, 0);
        alarm_en = 1'b1;
        step(1'b0, 1'b0, 1'b0);

        // Reset mid-ring
        arm();
        secs(30);
        chk("ring_mid", ring, 1);
        rst = 1'b1; #1;
        chk("rst_async_ring", ring, 0);
        chk("rst_async_beep", beep, 0);
        chk("rst_async_left", snooze_left, 0);
        step(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        secs(5);
        chk("no_ring_after_rst", ring, 0);
        arm();
        chk("ring_next_match", ring, 1);

        // Release reset while already matching
        rst = 1'b1; tm = 7; ts = 0;
        step(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        step(1'b0, 1'b0, 1'b0);
        chk("ring_on_release", ring, 1);
        step(1'b0, 1'b1, 1'b0);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            int r;
            bit t;
            r = $urandom_range(0, 99);
            if (r < 3) begin tm = 6; ts = 59; end
            else if (r < 6) begin tm = 7; ts = 0; end
            else if (r < 7) begin tm = $urandom_range(0, 59); ts = $urandom_range(0, 59); end
            alarm_en = ($urandom_range(0, 99) != 0);
            if (r == 99) begin
                rst = 1'b1;
                step(1'b0, 1'b0, 1'b0);
                rst = 1'b0;
            end
            t = ($urandom_range(0, 2) == 0);
            if (t) adv_time();
            step(t, $urandom_range(0, 39) == 0, $urandom_range(0, 19) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
